// File: rtl/keypad_pkg.sv
// Shared types and the hex key map for the keypad entry path.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAND    = 2'd1,
    ACCEPT  = 2'd2,
    PRESSED = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    ONE   = 2'd1,
    MULTI = 2'd2
  } frame_kind_t;

  // Indexed [row][col]; col 0 is the leftmost keypad column.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

endpackage

// File: rtl/keypad_matrix_scanner.sv
// Walks one active-low column per scan tick and reduces a 4-column frame
// to NONE / ONE(code) / MULTI, reported with a 1-cycle frame_done pulse.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        frame_done,
  output frame_kind_t frame_kind,
  output logic [3:0]  frame_code
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [TW-1:0] r_tick_cnt;
  logic [1:0]    r_col_idx;
  logic [3:0]    r_row_s1;
  logic [3:0]    r_row_s2;
  logic          r_seen;
  logic          r_multi;
  logic [3:0]    r_code;
  logic          r_frame_done;
  frame_kind_t   r_frame_kind;
  logic [3:0]    r_frame_code;

  logic          w_tick;
  logic [3:0]    w_low;
  logic [2:0]    w_nlow;
  logic [1:0]    w_row_idx;
  logic          w_col_one;
  logic          w_acc_seen;
  logic          w_acc_multi;
  logic [3:0]    w_acc_code;

  assign w_tick = (r_tick_cnt == TW'(DIV - 1));
  assign col    = ~(4'b0001 << r_col_idx);
  assign w_low  = ~r_row_s2;
  assign w_nlow = {2'b00, w_low[0]} + {2'b00, w_low[1]} + {2'b00, w_low[2]} + {2'b00, w_low[3]};

  always_comb begin
    w_row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (w_low[r]) w_row_idx = 2'(r);
    end
  end

  // A second low row in this column, or a low row in a second column, is ghosting.
  assign w_col_one   = (w_nlow == 3'd1);
  assign w_acc_seen  = r_seen | w_col_one;
  assign w_acc_multi = r_multi | (w_nlow > 3'd1) | (w_col_one & r_seen);
  assign w_acc_code  = (w_col_one && !r_seen) ? KEY_MAP[w_row_idx][r_col_idx] : r_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt   <= '0;
      r_col_idx    <= 2'd0;
      r_row_s1     <= 4'hF;
      r_row_s2     <= 4'hF;
      r_seen       <= 1'b0;
      r_multi      <= 1'b0;
      r_code       <= 4'h0;
      r_frame_done <= 1'b0;
      r_frame_kind <= NONE;
      r_frame_code <= 4'h0;
    end else begin
      r_row_s1     <= row;
      r_row_s2     <= r_row_s1;
      r_frame_done <= 1'b0;
      if (w_tick) begin
        r_tick_cnt <= '0;
        r_col_idx  <= r_col_idx + 2'd1;
        if (r_col_idx == 2'd3) begin
          r_frame_done <= 1'b1;
          r_frame_kind <= w_acc_multi ? MULTI : (w_acc_seen ? ONE : NONE);
          r_frame_code <= w_acc_code;
          r_seen       <= 1'b0;
          r_multi      <= 1'b0;
          r_code       <= 4'h0;
        end else begin
          r_seen  <= w_acc_seen;
          r_multi <= w_acc_multi;
          r_code  <= w_acc_code;
        end
      end else begin
        r_tick_cnt <= r_tick_cnt + 1'b1;
      end
    end
  end

  assign frame_done = r_frame_done;
  assign frame_kind = r_frame_kind;
  assign frame_code = r_frame_code;

endmodule

// File: rtl/hex_keypad_entry.sv
// Keypad front end: debounces scanned frames into single key events and
// shifts each accepted digit into a 32-bit entry register with a load strobe.
module hex_keypad_entry
  import keypad_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clear,
  output logic [31:0] number,
  output logic        load,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [3:0]  digit_count,
  output kp_state_t   dbg_state
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  logic        w_frame_done;
  frame_kind_t w_frame_kind;
  logic [3:0]  w_frame_code;

  kp_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]  r_cand, w_cand_nxt;
  logic        w_accept;

  logic [31:0] r_number;
  logic [3:0]  r_digit_count;
  logic        r_load;
  logic        r_key_valid;
  logic [3:0]  r_key_code;

  // Reset asserts immediately but releases two clocks later, glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  keypad_matrix_scanner #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) u_scanner (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .row        (row),
    .col        (col),
    .frame_done (w_frame_done),
    .frame_kind (w_frame_kind),
    .frame_code (w_frame_code)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    unique case (r_state)
      IDLE: begin
        if (w_frame_done && w_frame_kind == ONE) begin
          w_state_nxt = CAND;
          w_cand_nxt  = w_frame_code;
          w_cnt_nxt   = CW'(1);
        end
      end
      CAND: begin
        if (w_frame_done) begin
          if (w_frame_kind == ONE && w_frame_code == r_cand) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= CW'(DEBOUNCE_SCANS)) w_state_nxt = ACCEPT;
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      ACCEPT: begin
        w_state_nxt = PRESSED;
        w_cnt_nxt   = '0;
      end
      PRESSED: begin
        // Any key activity, including ghosted combinations, restarts the release count.
        if (w_frame_done) begin
          if (w_frame_kind == NONE) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc >= CW'(DEBOUNCE_SCANS)) begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_accept = (r_state == ACCEPT);

  // Strobes are registered alongside number so load always sees the updated value.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_number      <= 32'h0;
      r_digit_count <= 4'd0;
      r_load        <= 1'b0;
      r_key_valid   <= 1'b0;
      r_key_code    <= 4'h0;
    end else begin
      r_load      <= 1'b0;
      r_key_valid <= 1'b0;
      if (w_accept) begin
        r_key_valid <= 1'b1;
        r_key_code  <= r_cand;
      end
      if (clear) begin
        r_number      <= 32'h0;
        r_digit_count <= 4'd0;
        r_load        <= 1'b1;
      end else if (w_accept) begin
        r_number <= {r_number[27:0], r_cand};
        r_load   <= 1'b1;
        if (r_digit_count != 4'd8) r_digit_count <= r_digit_count + 4'd1;
      end
    end
  end

  assign number      = r_number;
  assign load        = r_load;
  assign key_valid   = r_key_valid;
  assign key_code    = r_key_code;
  assign digit_count = r_digit_count;
  assign dbg_state   = r_state;

endmodule
